// File: rtl/acc_pkg.sv
// Shared types and sizing constants for the accumulator datapath.
// The result FIFO pulls its default depth, counter width and pointer types from here.
package acc_pkg;

  localparam int DATA_WIDTH = 32;
  typedef logic [DATA_WIDTH-1:0] data_t;

  localparam int FIFO_DEPTH = 4;
  localparam int DROP_CNT_W = 8;

  typedef logic [$clog2(FIFO_DEPTH)-1:0] ptr_t;
  typedef logic [$clog2(FIFO_DEPTH):0]   cnt_t;

endpackage

// File: rtl/acc_result_fifo_if.sv
// Push/pop handshake between the accumulator, the result FIFO and its consumer.
// The master side produces results and accepts them; the slave side is the FIFO.
interface acc_result_fifo_if #(
  parameter int DATA_WIDTH = acc_pkg::DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] y_i;
  logic                  y_valid_i;
  logic [DATA_WIDTH-1:0] dout_o;
  logic                  valid_o;
  logic                  ready_i;

  modport master (
    output y_i,
    output y_valid_i,
    output ready_i,
    input  dout_o,
    input  valid_o
  );

  modport slave (
    input  y_i,
    input  y_valid_i,
    input  ready_i,
    output dout_o,
    output valid_o
  );

endinterface

// File: rtl/acc_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clr_i wins over inc_i.
// Used to tally results lost to FIFO overflow.
module acc_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] cnt_q;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    if (&v) begin
      return v;
    end
    return v + WIDTH'(1);
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/acc_result_fifo.sv
// Circular result buffer behind the accumulator: stores strobed results, hands them
// to a stalling consumer over valid/ready, and tallies words lost when it is full.
module acc_result_fifo
  import acc_pkg::*;
#(
  parameter int DATA_WIDTH = acc_pkg::DATA_WIDTH,
  parameter int DEPTH      = acc_pkg::FIFO_DEPTH,
  parameter int DROP_CNT_W = acc_pkg::DROP_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  acc_result_fifo_if.slave        io,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    full_o,
  output logic [DROP_CNT_W-1:0]   drop_cnt_o,
  output logic                    ovf_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic [CNT_W-1:0] count_d,  count_q;
  logic             ovf_d,    ovf_q;

  logic not_empty;
  logic pop;
  logic push_acc;
  logic drop;
  logic mem_we;

  assign not_empty = (count_q != '0);

  // A full FIFO still takes a push when the head leaves in the same cycle.
  always_comb begin
    pop      = not_empty && io.ready_i;
    push_acc = io.y_valid_i && ((count_q < DEPTH_C) || pop);
    drop     = io.y_valid_i && !push_acc;
    mem_we   = push_acc && !clr_i;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_acc) - CNT_W'(pop);
      if (drop) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage carries no reset; only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= io.y_i;
    end
  end

  acc_sat_counter #(
    .WIDTH (DROP_CNT_W)
  ) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clr_i),
    .inc_i (drop),
    .cnt_o (drop_cnt_o)
  );

  // Gate the head so an empty FIFO presents zero rather than stale storage.
  assign io.dout_o  = not_empty ? mem_q[rd_ptr_q] : '0;
  assign io.valid_o = not_empty;
  assign count_o    = count_q;
  assign full_o     = (count_q == DEPTH_C);
  assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_acc_result_fifo.sv
// Scoreboard bench for acc_result_fifo: directed scenarios plus a randomised
// push/pop stretch across pointer wrap, with a negedge monitor checking every pop.
module tb_acc_result_fifo;
  import acc_pkg::*;

  logic clk;
  logic rst_n;
  logic clr;
  logic [2:0] count_o;
  logic       full_o;
  logic [7:0] drop_cnt_o;
  logic       ovf_o;

  acc_result_fifo_if #(.DATA_WIDTH(32)) bus ();

  acc_result_fifo #(
    .DATA_WIDTH (32),
    .DEPTH      (4),
    .DROP_CNT_W (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr),
    .io         (bus),
    .count_o    (count_o),
    .full_o     (full_o),
    .drop_cnt_o (drop_cnt_o),
    .ovf_o      (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  data_t exp_q[$];
  int    m_cnt  = 0;
  int    m_drop = 0;
  bit    m_ovf  = 1'b0;
  int    n_acc  = 0;
  int    n_pop  = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Drive one cycle of inputs, record expectations, advance past the edge.
  task automatic step(input bit v, input logic [31:0] d, input bit r, input bit c);
    bit pop, acc;
    int nc, nd;
    bit no;
    bus.y_valid_i = v;
    bus.y_i       = d;
    bus.ready_i   = r;
    clr           = c;
    pop = (m_cnt != 0) && r;
    acc = v && ((m_cnt < 4) || pop);
    nc = m_cnt; nd = m_drop; no = m_ovf;
    if (c) begin
      nc = 0; nd = 0; no = 1'b0;
    end else begin
      if (acc) begin
        exp_q.push_back(d);
        n_acc++;
      end
      if (v && !acc) begin
        if (nd < 255) nd++;
        no = 1'b1;
      end
      nc = m_cnt + int'(acc) - int'(pop);
    end
    @(posedge clk);
    #1;
    if (c) exp_q.delete();
    m_cnt = nc; m_drop = nd; m_ovf = no;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_count"}, 32'(count_o), 32'd0);
    chk({tag, "_valid"}, 32'(bus.valid_o), 32'd0);
    chk({tag, "_full"},  32'(full_o), 32'd0);
    chk({tag, "_drop"},  32'(drop_cnt_o), 32'd0);
    chk({tag, "_ovf"},   32'(ovf_o), 32'd0);
    chk({tag, "_dout"},  bus.dout_o, 32'd0);
  endtask

  // Monitor: tracks status against the model and checks every pop's data.
  bit    bp_prev  = 1'b0;
  bit    clr_prev = 1'b0;
  data_t bp_dout;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("mon_count", 32'(count_o), 32'(m_cnt));
      chk("mon_le_depth", 32'(count_o <= 3'd4), 32'd1);
      chk("mon_valid", 32'(bus.valid_o), 32'(m_cnt != 0));
      chk("mon_full", 32'(full_o), 32'(m_cnt == 4));
      chk("mon_drop", 32'(drop_cnt_o), 32'(m_drop));
      chk("mon_ovf", 32'(ovf_o), 32'(m_ovf));
      if (bp_prev && !clr_prev) begin
        chk("bp_valid", 32'(bus.valid_o), 32'd1);
        chk("bp_dout", bus.dout_o, bp_dout);
      end
      if (bus.valid_o && bus.ready_i && !clr) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_unexpected: got %h want none at %0t", bus.dout_o, $time);
        end else begin
          chk("pop_dout", bus.dout_o, exp_q.pop_front());
          n_pop++;
        end
      end
      bp_prev  = bus.valid_o && !bus.ready_i;
      bp_dout  = bus.dout_o;
      clr_prev = clr;
    end else begin
      bp_prev = 1'b0;
    end
  end

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    bus.y_valid_i = 1'b0;
    bus.y_i       = '0;
    bus.ready_i   = 1'b0;
    #1;
    check_idle("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fill with 1..4 under stall, then drain in order.
    for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
    chk("fill_count", 32'(count_o), 32'd4);
    chk("fill_full", 32'(full_o), 32'd1);
    chk("fill_dout", bus.dout_o, 32'h1);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("drain_valid", 32'(bus.valid_o), 32'd0);
    chk("drain_count", 32'(count_o), 32'd0);

    // Overflow drop, then push-with-pop while full.
    for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("drop_cnt", 32'(drop_cnt_o), 32'd1);
    chk("drop_ovf", 32'(ovf_o), 32'd1);
    chk("drop_count", 32'(count_o), 32'd4);
    chk("drop_dout", bus.dout_o, 32'h1);
    step(1'b1, 32'hA5A5_A5A5, 1'b1, 1'b0);
    chk("fullpp_count", 32'(count_o), 32'd4);
    chk("fullpp_drop", 32'(drop_cnt_o), 32'd1);
    chk("fullpp_dout", bus.dout_o, 32'h2);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("fullpp_empty", 32'(bus.valid_o), 32'd0);

    // Push into empty with ready high: no bypass, one-cycle latency.
    step(1'b1, 32'h10, 1'b1, 1'b0);
    chk("lat_valid", 32'(bus.valid_o), 32'd1);
    chk("lat_dout", bus.dout_o, 32'h10);
    chk("lat_count", 32'(count_o), 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("lat_count_after", 32'(count_o), 32'd0);

    // Saturate the drop counter, then flush with a concurrent push.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, 32'hBAD0_0000 + 32'(i), 1'b0, 1'b0);
    chk("sat_drop", 32'(drop_cnt_o), 32'd255);
    chk("sat_ovf", 32'(ovf_o), 32'd1);
    chk("sat_dout", bus.dout_o, 32'h100);
    step(1'b1, 32'h7777_7777, 1'b0, 1'b1);
    check_idle("clr");
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("clr_still_empty", 32'(count_o), 32'd0);

    // Random traffic across many pointer wraps.
    n_acc = 0;
    n_pop = 0;
    for (int i = 0; i < 1000; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1, 1'b0);
    chk("conserve", 32'(n_acc), 32'(n_pop) + 32'(count_o));
    for (int i = 0; i < 8 && m_cnt != 0; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("rand_drained", 32'(count_o), 32'd0);
    chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in the middle of traffic.
    step(1'b1, 32'h55, 1'b0, 1'b0);
    step(1'b1, 32'h66, 1'b1, 1'b0);
    bus.y_valid_i = 1'b0;
    bus.ready_i   = 1'b0;
    rst_n = 1'b0;
    m_cnt = 0; m_drop = 0; m_ovf = 1'b0;
    exp_q.delete();
    #1;
    check_idle("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 32'h99, 1'b0, 1'b0);
    chk("post_rst_dout", bus.dout_o, 32'h99);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acc_result_fifo.md
Name: acc_result_fifo

Overview:
- Downstream stage of the accumulator datapath. Captures each accumulator result word `y_i`, strobed by `y_valid_i`, into a small circular FIFO.
- Presents buffered results to a consumer over a valid/ready handshake. Decouples the accumulator's free-running output from a stalling sink.
- Counts results dropped on overflow and raises a sticky overflow flag. The bench scoreboard reads these to detect lost sums.

Parameters:
- DATA_WIDTH, 32: result word width; equals acc_pkg::DATA_WIDTH.
- DEPTH, 4: FIFO entries; power of two, >= 2.
- DROP_CNT_W, 8: drop counter width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr_i  in  1  synchronous flush: empties the FIFO, clears drop_cnt_o and ovf_o.
- y_i  in  DATA_WIDTH  accumulator result (data_t).
- y_valid_i  in  1  one-cycle push strobe; y_i is valid in that cycle.
- dout_o  out  DATA_WIDTH  head entry; meaningful only while valid_o = 1.
- valid_o  out  1  FIFO non-empty.
- ready_i  in  1  consumer accepts; a pop occurs when valid_o && ready_i.
- count_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full_o  out  1  count_o == DEPTH.
- drop_cnt_o  out  DROP_CNT_W  number of dropped pushes; saturates at all-ones.
- ovf_o  out  1  sticky; set on the first drop.

Behaviour:
- Reset (rst_n = 0, async): rd_ptr = wr_ptr = 0; count_o = 0; valid_o = 0; full_o = 0; drop_cnt_o = 0; ovf_o = 0; dout_o = 0. Storage array contents are not reset.
- Event definitions: pop = valid_o && ready_i. push = y_valid_i.
- Push accept condition: accepted if count < DEPTH, or if count == DEPTH and pop occurs in the same cycle.
- Accepted push: mem[wr_ptr] <= y_i; wr_ptr increments mod DEPTH (natural wrap, power-of-two depth).
- Pop: rd_ptr increments mod DEPTH.
- Occupancy update: count += push_acc - pop.
- dout_o = mem[rd_ptr], combinational read from the array. It must stay stable while valid_o && !ready_i.
- Latency: a push in cycle N gives valid_o = 1 and dout_o = that word in cycle N+1. There is no same-cycle bypass.
- Empty with simultaneous push and ready_i: no pop occurs (valid_o = 0); the word is stored; count becomes 1.
- Full with push and pop in the same cycle: both succeed; count stays DEPTH; no drop.
- Full with push and no pop: the word is discarded and FIFO contents are unchanged.
  - drop_cnt_o increments unless already all-ones.
  - ovf_o <= 1.
- clr_i = 1 has priority over push and pop in that cycle:
  - Pointers and count go to 0; drop_cnt_o = 0; ovf_o = 0.
  - A push in the clr_i cycle is discarded and not counted as a drop.
  - Outputs take reset values in the next cycle.
- Reset asserted mid-stream: all in-flight words are lost; outputs follow reset values immediately (asynchronous).
- Ordering: strict FIFO. No duplication; no reordering.
- Assertions (bench-side binds):
  - count_o <= DEPTH.
  - No pop while !valid_o.
  - dout_o stable under backpressure.

Decomposition:
- acc_pkg gains FIFO_DEPTH = 4, DROP_CNT_W = 8, and typedefs ptr_t (logic [$clog2(FIFO_DEPTH)-1:0]) and cnt_t (logic [$clog2(FIFO_DEPTH):0]).
- Reuse the existing data_t for y_i / dout_o.
- One sub-module: acc_sat_counter, parameterised by width, with inc/clr inputs and saturation at all-ones. It implements drop_cnt_o.
- The FIFO core stays inline.

Test Plan:
- Reset, then push 0x0000_0001..0x0000_0004 with ready_i = 0 -> count_o = 4, full_o = 1, dout_o = 0x1. Then ready_i = 1 for 4 cycles -> pops 1, 2, 3, 4 in order; valid_o falls after the last pop.
- Full FIFO, push 0xDEAD_BEEF with ready_i = 0 -> drop_cnt_o = 1, ovf_o = 1, contents unchanged, dout_o = 0x1.
- Full FIFO, push 0xA5A5_A5A5 with ready_i = 1 in the same cycle -> no drop, count_o stays 4, 0xA5A5_A5A5 emerges as the 4th pop afterwards.
- Push 0x10 into empty FIFO with ready_i = 1 -> cycle N+1 valid_o = 1, dout_o = 0x10; popped in N+1; count_o back to 0 in N+2.
- 300 pushes into a full, stalled FIFO -> drop_cnt_o saturates at 255. Then clr_i concurrent with a push -> next cycle count_o = 0, drop_cnt_o = 0, ovf_o = 0, valid_o = 0.
- Continuous push/pop with random ready_i for 1000 cycles across pointer wrap -> scoreboard order matches, and accepted count equals popped count plus final count_o.
